// File: rtl/mul_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mul_ctrl_pkg
//   Shared definitions for the EX-stage multiply sequencer: operand widths,
//   multiply op encodings (MULOP_*), sequencer state encodings (MC_*), and a
//   helper that tells whether an op treats its operands as signed.
// ---------------------------------------------------------------------------
package mul_ctrl_pkg;

    localparam int MC_W    = 32;
    localparam int MC_OP_W = 3;

    // Multiply op encodings as presented by EX decode; 7 is reserved.
    typedef enum logic [MC_OP_W-1:0] {
        MULOP_MULT  = 3'd0,
        MULOP_MULTU = 3'd1,
        MULOP_MUL   = 3'd2,
        MULOP_MADD  = 3'd3,
        MULOP_MADDU = 3'd4,
        MULOP_MSUB  = 3'd5,
        MULOP_MSUBU = 3'd6,
        MULOP_RSVD  = 3'd7
    } mulop_e;

    // Sequencer states: operand capture, multiply, accumulate, result.
    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_MUL  = 2'd1,
        MC_ACC  = 2'd2,
        MC_DONE = 2'd3
    } mc_state_e;

    // Signed ops sign-extend both operands into the multiplier.
    function automatic logic mulop_is_signed(mulop_e o);
        return (o == MULOP_MULT) || (o == MULOP_MUL) ||
               (o == MULOP_MADD) || (o == MULOP_MSUB);
    endfunction

endpackage

// File: rtl/mul_booth2.sv
// ---------------------------------------------------------------------------
// mul_booth2
//   Combinational radix-4 (booth-2) multiplier producing a 2W-bit product.
//   Ports:
//     a      in  W    multiplicand
//     b      in  W    multiplier
//     sign   in  1    1: treat a and b as two's complement, 0: unsigned
//     result out 2W   product, exact for both signed and unsigned operands
// ---------------------------------------------------------------------------
module mul_booth2
    import mul_ctrl_pkg::*;
#(
    parameter int W = MC_W
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           sign,
    output logic [2*W-1:0] result
);

    // b is widened by two bits (sign or zero) so it has an even number of
    // bits and its two's-complement value equals the intended operand value;
    // that gives (W+2)/2 booth digits covering both signed and unsigned b.
    localparam int NDIG = (W + 2) / 2;

    logic           b_ext_bit;
    logic [W+2:0]   b_pad;
    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] pp;
    logic [2*W-1:0] acc;

    assign b_ext_bit = sign & b[W-1];
    assign b_pad     = {b_ext_bit, b_ext_bit, b, 1'b0};
    assign a_ext     = {{W{sign & a[W-1]}}, a};

    // Each overlapping bit triple selects a digit in {-2,-1,0,+1,+2}; the
    // selected multiple of a is weighted by 4^i and summed modulo 2^(2W),
    // which is exact because the true product always fits in 2W bits.
    always_comb begin
        acc = '0;
        pp  = '0;
        for (int i = 0; i < NDIG; i++) begin
            case (b_pad[2*i +: 3])
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext << 1;
                3'b100:         pp = -(a_ext << 1);
                3'b101, 3'b110: pp = -a_ext;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2 * i));
        end
        result = acc;
    end

endmodule

// File: rtl/mul_ctrl.sv
// ---------------------------------------------------------------------------
// mul_ctrl
//   EX-stage multiply sequencer. Captures operands and {HI,LO}, runs one
//   booth-2 multiply, applies the HI/LO accumulate and presents the 64-bit
//   result for one cycle while holding IF..EX stalled until then.
//   Ports:
//     clk        in   1     clock
//     rst        in   1     synchronous active-high reset
//     start      in   1     EX holds a multiply op (level)
//     op         in   OP_W  MULT/MULTU/MUL/MADD/MADDU/MSUB/MSUBU, 7 reserved
//     src_a      in   W     rs operand
//     src_b      in   W     rt operand
//     hilo_in    in   2W    forwarded {HI,LO}
//     flush      in   1     abort the op in EX
//     stall      out  1     freeze IF..EX
//     valid_out  out  1     one-cycle result pulse
//     result     out  2W    {HI,LO} to write (MUL: low W bits are the GPR value)
//     hilo_we    out  1     write HI/LO this cycle
// ---------------------------------------------------------------------------
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int W    = MC_W,
    parameter int OP_W = MC_OP_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [W-1:0]    src_a,
    input  logic [W-1:0]    src_b,
    input  logic [2*W-1:0]  hilo_in,
    input  logic            flush,
    output logic            stall,
    output logic            valid_out,
    output logic [2*W-1:0]  result,
    output logic            hilo_we
);

    mc_state_e      state_q;
    mc_state_e      state_d;
    mulop_e         op_in;
    mulop_e         op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [2*W-1:0] hilo_q;
    logic [2*W-1:0] prod_q;
    logic [2*W-1:0] res_q;
    logic [2*W-1:0] product;
    logic [2*W-1:0] acc_sum;
    logic           load;

    assign op_in = mulop_e'(op);

    // The single multiplier only ever sees the captured operands, so the
    // result path has no combinational dependence on src_a/src_b.
    mul_booth2 #(
        .W(W)
    ) u_mul (
        .a      (a_q),
        .b      (b_q),
        .sign   (mulop_is_signed(op_q)),
        .result (product)
    );

    // HI/LO accumulate; all arithmetic wraps modulo 2^(2W).
    always_comb begin
        acc_sum = prod_q;
        case (op_q)
            MULOP_MADD, MULOP_MADDU: acc_sum = hilo_q + prod_q;
            MULOP_MSUB, MULOP_MSUBU: acc_sum = hilo_q - prod_q;
            default:                 acc_sum = prod_q;
        endcase
    end

    // State register plus operand/product/result capture. A flush in MUL or
    // ACC leaves the pipeline registers untouched since the op is abandoned.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MC_IDLE;
            op_q    <= MULOP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hilo_q  <= '0;
            prod_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                op_q   <= op_in;
                a_q    <= src_a;
                b_q    <= src_b;
                hilo_q <= hilo_in;
            end
            if (state_q == MC_MUL && !flush) begin
                prod_q <= product;
            end
            if (state_q == MC_ACC && !flush) begin
                res_q <= acc_sum;
            end
        end
    end

    // Next-state and state-decoded outputs. DONE always returns to IDLE: a
    // start still seen in DONE is the instruction that just finished, so it
    // must not launch again. Stall drops in DONE so EX can advance.
    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        valid_out = 1'b0;
        hilo_we   = 1'b0;
        load      = 1'b0;
        case (state_q)
            MC_IDLE: begin
                if (start && !flush && op_in != MULOP_RSVD) begin
                    load    = 1'b1;
                    stall   = 1'b1;
                    state_d = MC_MUL;
                end
            end
            MC_MUL: begin
                if (flush) begin
                    state_d = MC_IDLE;
                end else begin
                    stall   = 1'b1;
                    state_d = MC_ACC;
                end
            end
            MC_ACC: begin
                if (flush) begin
                    state_d = MC_IDLE;
                end else begin
                    stall   = 1'b1;
                    state_d = MC_DONE;
                end
            end
            MC_DONE: begin
                state_d = MC_IDLE;
                if (!flush) begin
                    valid_out = 1'b1;
                    hilo_we   = (op_q != MULOP_MUL);
                end
            end
            default: state_d = MC_IDLE;
        endcase
    end

    assign result = res_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul_ctrl
//   Self-checking bench for mul_ctrl: directed cases with literal results,
//   then randomized traffic, all compared every cycle against a reference
//   model built from op semantics and a simple "cycles since accept" count.
// ---------------------------------------------------------------------------
module tb_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [63:0] hilo_in;
    logic        flush;
    logic        stall;
    logic        valid_out;
    logic [63:0] result;
    logic        hilo_we;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    mul_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .hilo_in   (hilo_in),
        .flush     (flush),
        .stall     (stall),
        .valid_out (valid_out),
        .result    (result),
        .hilo_we   (hilo_we)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One comparison: bumps the check count and reports any difference.
    task automatic checkOutput(input string name, input logic [63:0] got,
                               input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    // Architectural meaning of each op, straight from the ISA definition.
    function automatic logic [63:0] refResult(input logic [2:0] o,
                                              input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [63:0] h);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (o == 3'd0 || o == 3'd2 || o == 3'd3 || o == 3'd5) p = sa * sb;
        else p = ua * ub;
        case (o)
            3'd3, 3'd4: return h + p;
            3'd5, 3'd6: return h - p;
            default:    return p;
        endcase
    endfunction

    // Reference model: age counts cycles since an op was accepted; the
    // result is computed the moment the op is accepted.
    int          age = 0;
    logic [63:0] m_res = '0;
    logic        m_we = 1'b0;

    always @(posedge clk) begin
        if (rst || flush) begin
            age = 0;
        end else if (age == 0) begin
            if (start && op != 3'd7) begin
                age   = 1;
                m_res = refResult(op, src_a, src_b, hilo_in);
                m_we  = (op != 3'd2);
            end
        end else if (age >= 3) begin
            age = 0;
        end else begin
            age = age + 1;
        end
    end

    // Every-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            bit accept;
            bit e_stall;
            bit e_valid;
            accept  = (age == 0) && start && !flush && (op != 3'd7);
            e_stall = !flush && (accept || age == 1 || age == 2);
            e_valid = !flush && (age == 3);
            checkOutput("stall", 64'(stall), 64'(e_stall));
            checkOutput("valid_out", 64'(valid_out), 64'(e_valid));
            checkOutput("hilo_we", 64'(hilo_we), 64'(e_valid && m_we));
            if (e_valid) checkOutput("result", result, m_res);
        end
    end

    // Presents one op just after a clock edge and follows it to its result
    // pulse. start stays high through DONE; the caller decides what EX
    // presents afterwards.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [63:0] h,
                                 output logic [63:0] res, output logic we,
                                 output int nstall, output int lat,
                                 output int vt);
        int t0;
        bit seen;
        seen   = 1'b0;
        res    = '0;
        we     = 1'b0;
        nstall = 0;
        lat    = -1;
        vt     = -1;
        start   = 1'b1;
        op      = o;
        src_a   = a;
        src_b   = b;
        hilo_in = h;
        t0      = cyc;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (stall) nstall++;
            if (valid_out) begin
                seen = 1'b1;
                res  = result;
                we   = hilo_we;
                lat  = cyc - t0;
                vt   = cyc;
            end
            @(posedge clk);
            #1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout: no valid_out for op %0d within 8 cycles", o);
        end
    endtask

    task automatic idleCycles(input int n);
        start = 1'b0;
        flush = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts result pulses over the next n cycles with start low.
    task automatic countValid(input int n, output int cnt);
        cnt   = 0;
        start = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (valid_out) cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom % 6)
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [63:0] res;
    logic        we;
    int          nst;
    int          lat;
    int          vt1;
    int          vt2;
    int          cnt;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        flush   = 1'b0;
        op      = 3'd0;
        src_a   = '0;
        src_b   = '0;
        hilo_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state.
        @(negedge clk);
        checkOutput("reset_stall", 64'(stall), 64'd0);
        checkOutput("reset_valid", 64'(valid_out), 64'd0);
        checkOutput("reset_we", 64'(hilo_we), 64'd0);
        checkOutput("reset_result", result, 64'd0);
        @(posedge clk);
        #1;

        // MULT -2 * 3.
        applyStimulus(3'd0, 32'hFFFF_FFFE, 32'd3, 64'd0, res, we, nst, lat, vt1);
        start = 1'b0;
        checkOutput("mult_result", res, 64'hFFFF_FFFF_FFFF_FFFA);
        checkOutput("mult_we", 64'(we), 64'd1);
        checkOutput("mult_stall_cycles", 64'(nst), 64'd3);
        checkOutput("mult_latency", 64'(lat), 64'd3);
        idleCycles(1);

        // MULTU max * max.
        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, res, we, nst, lat, vt1);
        start = 1'b0;
        checkOutput("multu_result", res, 64'hFFFF_FFFE_0000_0001);
        idleCycles(1);

        // MADD: 0x10 + (-1 * 4).
        applyStimulus(3'd3, 32'hFFFF_FFFF, 32'd4, 64'h10, res, we, nst, lat, vt1);
        start = 1'b0;
        checkOutput("madd_result", res, 64'h0000_0000_0000_000C);
        idleCycles(1);

        // MSUBU wraps below zero.
        applyStimulus(3'd6, 32'd1, 32'd1, 64'd0, res, we, nst, lat, vt1);
        start = 1'b0;
        checkOutput("msubu_result", res, 64'hFFFF_FFFF_FFFF_FFFF);
        idleCycles(1);

        // MUL with start held through DONE: one pulse, no HI/LO write.
        applyStimulus(3'd2, 32'd7, 32'd6, 64'h1234, res, we, nst, lat, vt1);
        checkOutput("mul_gpr", 64'(res[31:0]), 64'd42);
        checkOutput("mul_we", 64'(we), 64'd0);
        countValid(5, cnt);
        checkOutput("mul_no_relaunch", 64'(cnt), 64'd0);

        // Flush in ACC abandons the op.
        start   = 1'b1;
        op      = 3'd0;
        src_a   = 32'd5;
        src_b   = 32'd5;
        hilo_in = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        flush = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("flush_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        countValid(5, cnt);
        checkOutput("flush_no_valid", 64'(cnt), 64'd0);
        applyStimulus(3'd0, 32'd9, 32'hFFFF_FFFD, 64'd0, res, we, nst, lat, vt1);
        start = 1'b0;
        checkOutput("after_flush_result", res, 64'hFFFF_FFFF_FFFF_FFE5);
        idleCycles(1);

        // Reset pulsed while in MUL.
        start = 1'b1;
        op    = 3'd1;
        src_a = 32'd100;
        src_b = 32'd200;
        @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_stall", 64'(stall), 64'd0);
        checkOutput("rst_mid_valid", 64'(valid_out), 64'd0);
        checkOutput("rst_mid_we", 64'(hilo_we), 64'd0);
        checkOutput("rst_mid_result", result, 64'd0);
        @(posedge clk);
        #1;

        // Reserved op is a no-op.
        start = 1'b1;
        op    = 3'd7;
        @(negedge clk);
        checkOutput("rsvd_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        countValid(5, cnt);
        checkOutput("rsvd_no_valid", 64'(cnt), 64'd0);

        // Back-to-back MULTs: second accepted in the IDLE cycle after DONE.
        applyStimulus(3'd0, 32'd3, 32'd4, 64'd0, res, we, nst, lat, vt1);
        checkOutput("b2b_first", res, 64'd12);
        applyStimulus(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, res, we, nst, lat, vt2);
        start = 1'b0;
        checkOutput("b2b_second", res, 64'd1);
        checkOutput("b2b_spacing", 64'(vt2 - vt1), 64'd4);
        idleCycles(2);

        // Randomized traffic; the every-cycle compare does the checking.
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom % 64) == 0;
            flush   = ($urandom % 12) == 0;
            start   = ($urandom % 3) != 0;
            op      = 3'($urandom % 8);
            src_a   = pickOperand();
            src_b   = pickOperand();
            hilo_in = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        idleCycles(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
